// File: rtl/viterbi_tbu_if.sv
// Handshake bundle between the ACS array, the traceback unit and the bit consumer.
// VITERBI_TBU_MIN_METRIC_EN adds the min_metric signal used for metric normalisation.
interface viterbi_tbu_if #(
  parameter int unsigned STATE_BITS = 2,
  parameter int unsigned METRIC_W   = 4
);
  localparam int unsigned NS = 1 << STATE_BITS;

  logic                       in_valid;
  logic                       in_ready;
  logic [NS*METRIC_W-1:0]     path_cost;
  logic [NS-1:0]              decisions;
  logic [STATE_BITS-1:0]      min_state;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_bit;
`ifdef VITERBI_TBU_MIN_METRIC_EN
  logic [METRIC_W-1:0]        min_metric;
`endif

  modport master (
    output in_valid, path_cost, decisions, out_ready,
    input  in_ready, min_state, out_valid, out_bit
`ifdef VITERBI_TBU_MIN_METRIC_EN
    , input min_metric
`endif
  );

  modport slave (
    input  in_valid, path_cost, decisions, out_ready,
    output in_ready, min_state, out_valid, out_bit
`ifdef VITERBI_TBU_MIN_METRIC_EN
    , output min_metric
`endif
  );
endinterface

// File: rtl/viterbi_tbu.sv
// Viterbi traceback unit: minimum-cost state select, survivor memory and traceback FSM.
// VITERBI_TBU_MIN_METRIC_EN adds a registered min_metric output alongside min_state.
module viterbi_tbu #(
  parameter int unsigned STATE_BITS = 2,
  parameter int unsigned METRIC_W   = 4,
  parameter int unsigned TB_DEPTH   = 8
) (
  input logic         clk,
  input logic         rst,
  viterbi_tbu_if.slave bus
);
  localparam int unsigned NS     = 1 << STATE_BITS;
  localparam int unsigned PTR_W  = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(TB_DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

  typedef enum logic [1:0] {IDLE, TRACE, EMIT} state_t;

  state_t                state, state_nxt;
  logic [NS-1:0]         mem [TB_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, cnt;
  logic [FILL_W-1:0]     fill, fill_inc;
  logic [STATE_BITS-1:0] cur_state, sel_state;
  logic [METRIC_W-1:0]   sel_cost;
  logic                  accept;

  assign bus.in_ready = (state == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fill_inc     = (fill == FILL_FULL) ? fill : fill + 1'b1;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    sel_state = '0;
    sel_cost  = bus.path_cost[METRIC_W-1:0];
    for (int unsigned s = 1; s < NS; s++) begin
      if (bus.path_cost[s*METRIC_W +: METRIC_W] < sel_cost) begin
        sel_cost  = bus.path_cost[s*METRIC_W +: METRIC_W];
        sel_state = STATE_BITS'(s);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.out_valid = 1'b0;
    bus.out_bit   = 1'b0;
    case (state)
      IDLE:  if (accept && fill_inc == FILL_FULL) state_nxt = TRACE;
      TRACE: if (cnt == PTR_W'(1)) state_nxt = EMIT;
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_bit   = cur_state[STATE_BITS-1];
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      cnt           <= '0;
      cur_state     <= '0;
      bus.min_state <= '0;
`ifdef VITERBI_TBU_MIN_METRIC_EN
      bus.min_metric <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          cur_state     <= sel_state;
          bus.min_state <= sel_state;
`ifdef VITERBI_TBU_MIN_METRIC_EN
          bus.min_metric <= sel_cost;
`endif
          rd_ptr <= wr_ptr;
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
          fill   <= fill_inc;
          if (fill_inc == FILL_FULL) cnt <= PTR_LAST;
        end
        TRACE: begin
          // Step back one trellis stage: predecessor is {s[MSB-1:0], d}.
          cur_state <= {cur_state[STATE_BITS-2:0], mem[rd_ptr][cur_state]};
          rd_ptr    <= (rd_ptr == '0) ? PTR_LAST : rd_ptr - 1'b1;
          cnt       <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Survivor memory needs no reset: fill gating keeps stale rows unread.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.decisions;
  end
endmodule

// File: tb/tb_viterbi_tbu.sv
// Self-checking bench for viterbi_tbu (STATE_BITS=2, METRIC_W=4, TB_DEPTH=4) with a trellis reference model.
module tb_viterbi_tbu;
  localparam int unsigned SB = 2;
  localparam int unsigned MW = 4;
  localparam int unsigned TD = 4;
  localparam int unsigned NS = 1 << SB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_tbu_if #(.STATE_BITS(SB), .METRIC_W(MW)) bus ();
  viterbi_tbu #(.STATE_BITS(SB), .METRIC_W(MW), .TB_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: history of accepted steps, traced back by the trellis rules.
  int            mdl_fill;
  logic [NS-1:0] mdl_dec[$];
  int            mdl_min[$];

  function automatic int ref_min(input logic [NS*MW-1:0] c);
    int mv = 1 << 30;
    for (int s = 0; s < NS; s++) if (int'(c[s*MW +: MW]) < mv) mv = int'(c[s*MW +: MW]);
    for (int s = 0; s < NS; s++) if (int'(c[s*MW +: MW]) == mv) return s;
    return -1;
  endfunction

  function automatic int ref_cost(input logic [NS*MW-1:0] c, input int s);
    return int'(c[s*MW +: MW]);
  endfunction

  function automatic int ref_bit();
    int s = mdl_min[$];
    for (int j = 0; j < TD - 1; j++) begin
      logic [NS-1:0] row = mdl_dec[mdl_dec.size() - 1 - j];
      s = ((s * 2) % NS) + int'(row[s]);
    end
    return s / (NS / 2);
  endfunction

  task automatic mdl_reset();
    mdl_fill = 0;
    mdl_dec.delete();
    mdl_min.delete();
  endtask

  task automatic mdl_push(input logic [NS*MW-1:0] c, input logic [NS-1:0] d);
    mdl_dec.push_back(d);
    mdl_min.push_back(ref_min(c));
    if (mdl_dec.size() > TD) begin
      void'(mdl_dec.pop_front());
      void'(mdl_min.pop_front());
    end
    if (mdl_fill < TD) mdl_fill++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    mdl_reset();
  endtask

  task automatic drive_accept(input logic [NS*MW-1:0] c, input logic [NS-1:0] d);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    bus.path_cost = c;
    bus.decisions = d;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    mdl_push(c, d);
    check("min_state", bus.min_state, ref_min(c));
`ifdef VITERBI_TBU_MIN_METRIC_EN
    check("min_metric", bus.min_metric, ref_cost(c, ref_min(c)));
`endif
  endtask

  // One accept plus, once the buffer is full, the traceback and emit with hold cycles of backpressure.
  task automatic do_accept(input logic [NS*MW-1:0] c, input logic [NS-1:0] d,
                           input int hold, input int exp_const);
    int w;
    int exp_bit;
    drive_accept(c, d);
    if (mdl_fill < TD) begin
      check("no_out_valid", bus.out_valid, 0);
      check("idle_ready", bus.in_ready, 1);
      return;
    end
    exp_bit = ref_bit();
    w = 0;
    while (!bus.out_valid && w < 2 * int'(TD)) begin
      tick();
      w++;
    end
    check("emit_latency", w, TD - 1);
    check("out_bit", bus.out_bit, exp_bit);
    if (exp_const >= 0) check("out_bit_const", bus.out_bit, exp_const);
    check("emit_in_ready", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", bus.out_valid, 1);
      check("hold_bit", bus.out_bit, exp_bit);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_emit_valid", bus.out_valid, 0);
    check("post_emit_ready", bus.in_ready, 1);
  endtask

  typedef struct {
    logic [NS*MW-1:0] cost;
    logic [NS-1:0]    dec;
    int               exp_state;
    int               exp_metric;
  } vec_t;

  vec_t tie_tbl[3];

  initial begin
    logic [NS*MW-1:0] c;
    int lowcnt, rise, exp_bit, seen;

    tie_tbl[0] = '{cost: {4'd7, 4'd5, 4'd3, 4'd3}, dec: 4'b1010, exp_state: 0, exp_metric: 3};
    tie_tbl[1] = '{cost: {4'd1, 4'd2, 4'd2, 4'd9}, dec: 4'b0110, exp_state: 3, exp_metric: 1};
    tie_tbl[2] = '{cost: {4'd4, 4'd4, 4'd4, 4'd4}, dec: 4'b1101, exp_state: 0, exp_metric: 4};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.path_cost = '0;
    bus.decisions = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_bit", bus.out_bit, 0);
    check("rst_min_state", bus.min_state, 0);
`ifdef VITERBI_TBU_MIN_METRIC_EN
    check("rst_min_metric", bus.min_metric, 0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    mdl_reset();

    // Tie-break table; three accepts must not fill the buffer.
    for (int i = 0; i < 3; i++) begin
      drive_accept(tie_tbl[i].cost, tie_tbl[i].dec);
      check("tie_min_state", bus.min_state, tie_tbl[i].exp_state);
`ifdef VITERBI_TBU_MIN_METRIC_EN
      check("tie_min_metric", bus.min_metric, tie_tbl[i].exp_metric);
`endif
      check("fill_out_valid", bus.out_valid, 0);
      check("fill_in_ready", bus.in_ready, 1);
    end

    // Filling accept: in_ready low for exactly TD cycles, out_valid on the TD-th.
    bus.out_ready = 1'b1;
    drive_accept({4'd2, 4'd0, 4'd6, 4'd1}, 4'b0011);
    exp_bit = ref_bit();
    lowcnt = 0;
    rise = -1;
    for (int i = 0; i < 12; i++) begin
      if (!bus.in_ready) lowcnt++;
      if (bus.out_valid && rise < 0) begin
        rise = i;
        check("gating_out_bit", bus.out_bit, exp_bit);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    check("gating_ready_low_cycles", lowcnt, TD);
    check("gating_valid_rise", rise, TD - 1);

    // Backpressure: ten stalled EMIT cycles.
    do_accept({4'd3, 4'd1, 4'd0, 4'd2}, 4'b1001, 10, -1);

    do_reset();
    for (int i = 0; i < 6; i++) do_accept({4'd5, 4'd5, 4'd5, 4'd0}, 4'b0000, 0, 0);

    do_reset();
    for (int i = 0; i < 6; i++) do_accept({4'd0, 4'd5, 4'd5, 4'd5}, 4'b1111, 0, 1);

    // Reset on the second TRACE cycle drops the pending output and empties the buffer.
    do_reset();
    for (int i = 0; i < 3; i++) do_accept({4'(i), 4'd3, 4'd7, 4'd2}, 4'(i * 5), 0, -1);
    drive_accept({4'd1, 4'd2, 4'd3, 4'd4}, 4'b0101);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    mdl_reset();
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_min_state", bus.min_state, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 3; i++) do_accept({4'd6, 4'(i + 1), 4'd9, 4'd8}, 4'b1100, 0, -1);
    seen = 0;
    for (int i = 0; i < int'(TD) + 2; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("midrst_no_output", seen, 0);
    do_accept({4'd2, 4'd2, 4'd5, 4'd7}, 4'b0110, 1, -1);

    // Randomised stream with ties and random backpressure.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      for (int s = 0; s < NS; s++) c[s*MW +: MW] = MW'($urandom_range(0, 3));
      do_accept(c, NS'($urandom), int'($urandom_range(0, 3)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
